// File: rtl/fifo_write_arbiter_if.sv
// Write-side bundle between the two requesters, the arbiter and the video FIFO.
// The arbiter uses the slave view; whatever drives requesters and the FIFO flag uses master.
interface fifo_write_arbiter_if #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
);
    logic              req0_valid;
    logic [DATA_W-1:0] req0_data;
    logic              req0_last;
    logic              req0_ready;
    logic              req1_valid;
    logic [DATA_W-1:0] req1_data;
    logic              req1_last;
    logic              req1_ready;
    logic              fifo_full;
    logic              fifo_wr_en;
    logic [DATA_W-1:0] fifo_wr_data;
    logic [1:0]        grant;
    logic [CNT_W-1:0]  words0;
    logic [CNT_W-1:0]  words1;

    modport slave (
        input  req0_valid, req0_data, req0_last,
        output req0_ready,
        input  req1_valid, req1_data, req1_last,
        output req1_ready,
        input  fifo_full,
        output fifo_wr_en, fifo_wr_data, grant, words0, words1
    );

    modport master (
        output req0_valid, req0_data, req0_last,
        input  req0_ready,
        output req1_valid, req1_data, req1_last,
        input  req1_ready,
        output fifo_full,
        input  fifo_wr_en, fifo_wr_data, grant, words0, words1
    );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing the video FIFO write port between host writes (req0)
// and the blitter (req1), with bursts capped at BURST_MAX words per grant.
module fifo_write_arbiter #(
    parameter int DATA_W    = 16,
    parameter int BURST_MAX = 4,
    parameter int CNT_W     = 16
) (
    input logic                 clk,
    input logic                 rst,
    fifo_write_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, G0, G1} state_t;

    localparam logic [7:0] BURST_LIM = 8'(BURST_MAX);

    state_t            state_q, state_d;
    logic [7:0]        burst_cnt, burst_d;
    logic              last_served, last_served_d;
    logic [CNT_W-1:0]  words0_q, words1_q;

    logic              sel_valid;
    logic              sel_last;
    logic [DATA_W-1:0] sel_data;
    logic              other_valid;
    logic              accept;
    logic              release_grant;

    // Mux the granted requester onto the write path; IDLE selects nobody.
    always_comb begin
        sel_valid   = 1'b0;
        sel_last    = 1'b0;
        sel_data    = '0;
        other_valid = 1'b0;
        case (state_q)
            G0: begin
                sel_valid   = bus.req0_valid;
                sel_last    = bus.req0_last;
                sel_data    = bus.req0_data;
                other_valid = bus.req1_valid;
            end
            G1: begin
                sel_valid   = bus.req1_valid;
                sel_last    = bus.req1_last;
                sel_data    = bus.req1_data;
                other_valid = bus.req0_valid;
            end
            default: ;
        endcase
    end

    assign accept        = sel_valid & ~bus.fifo_full;
    assign release_grant = ~sel_valid | sel_last | ((burst_cnt + 8'd1) == BURST_LIM);

    assign bus.req0_ready   = (state_q == G0) & ~bus.fifo_full;
    assign bus.req1_ready   = (state_q == G1) & ~bus.fifo_full;
    assign bus.fifo_wr_en   = accept;
    assign bus.fifo_wr_data = sel_valid ? sel_data : '0;
    assign bus.grant        = {state_q == G1, state_q == G0};
    assign bus.words0       = words0_q;
    assign bus.words1       = words1_q;

    // A full FIFO freezes the grant entirely, even if the owner's valid drops.
    always_comb begin
        state_d       = state_q;
        burst_d       = burst_cnt;
        last_served_d = last_served;
        case (state_q)
            IDLE: begin
                if (bus.req0_valid && bus.req1_valid)
                    state_d = last_served ? G0 : G1;
                else if (bus.req0_valid)
                    state_d = G0;
                else if (bus.req1_valid)
                    state_d = G1;
            end
            G0, G1: begin
                if (!bus.fifo_full) begin
                    if (release_grant) begin
                        last_served_d = (state_q == G1);
                        burst_d       = 8'd0;
                        if (other_valid)
                            state_d = (state_q == G0) ? G1 : G0;
                        else
                            state_d = IDLE;
                    end else begin
                        burst_d = burst_cnt + 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            burst_cnt   <= 8'd0;
            last_served <= 1'b1;
            words0_q    <= '0;
            words1_q    <= '0;
        end else begin
            state_q     <= state_d;
            burst_cnt   <= burst_d;
            last_served <= last_served_d;
            if (accept && state_q == G0)
                words0_q <= words0_q + CNT_W'(1);
            if (accept && state_q == G1)
                words1_q <= words1_q + CNT_W'(1);
        end
    end

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Shares the single 16-bit write port of the video FIFO (async_fifo1) between two requesters: req0 (host bus writes) and req1 (blitter / pixel engine).
- Round-robin arbitration with bounded bursts. Forwards accepted words to the FIFO write port in the same cycle and honours the FIFO full flag.
- Sits in the write-clock domain, directly in front of the FIFO write side.

Parameters:
- DATA_W, 16, width of data words (matches FIFO data width)
- BURST_MAX, 4, maximum words accepted per grant before forced re-arbitration (1..255)
- CNT_W, 16, width of the per-requester accepted-word statistics counters

Ports:
- clk  in  1  write-side clock
- rst  in  1  asynchronous reset, active-high
- req0_valid  in  1  requester 0 has a word
- req0_data  in  DATA_W  requester 0 word
- req0_last  in  1  final word of requester 0 burst
- req0_ready  out  1  requester 0 word accepted this cycle when valid&ready
- req1_valid  in  1  requester 1 has a word
- req1_data  in  DATA_W  requester 1 word
- req1_last  in  1  final word of requester 1 burst
- req1_ready  out  1  requester 1 word accepted this cycle when valid&ready
- fifo_full  in  1  FIFO write-side full flag
- fifo_wr_en  out  1  FIFO write enable
- fifo_wr_data  out  DATA_W  FIFO write data
- grant  out  2  one-hot current owner; 2'b00 = none
- words0  out  CNT_W  count of words accepted from req0
- words1  out  CNT_W  count of words accepted from req1

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values:
  - state = IDLE, grant = 0, burst_cnt = 0, last_served = 1 (so req0 wins the first contention), words0 = words1 = 0.
  - Combinational outputs: req0_ready = req1_ready = fifo_wr_en = 0, fifo_wr_data = 0.
- Reset during operation: everything returns to reset values immediately. A partial burst is abandoned and no FIFO write occurs while rst is high.
- States:
  - IDLE: grant = 00.
  - G0: grant = 01.
  - G1: grant = 10.
- Ready and write path (combinational, zero latency):
  - reqN_ready = (state == GN) & ~fifo_full.
  - fifo_wr_en = accept, where accept = reqN_valid & reqN_ready for the granted N.
  - fifo_wr_data = granted reqN_data when the granted requester is valid, else 0.
- IDLE transitions (registered):
  - Only req0_valid → G0; only req1_valid → G1.
  - Both valid → the requester that is not last_served.
  - Neither valid → stay in IDLE.
  - No words are accepted in IDLE, so arbitration costs 1 cycle.
- In GN, on each accept: burst_cnt += 1 and wordsN += 1. wordsN wraps modulo 2^CNT_W.
- Release condition in GN: an accepted word with reqN_last = 1, OR burst_cnt + 1 == BURST_MAX on an accept, OR reqN_valid = 0 in that cycle.
- On release:
  - last_served = N and burst_cnt = 0.
  - Next state is G(other) if the other requester's valid is high in the same cycle, else IDLE. A back-to-back handover costs no idle cycle.
- fifo_full while in GN:
  - Ready stays low; grant, burst_cnt and state are held.
  - No timeout and no release. Valid held with FIFO full is not a release.
- The requester contract requires data and last to be stable while valid & ~ready.
- A losing requester's ready is 0 at all times.
- At most one fifo_wr_en per cycle. A word is never written while fifo_full = 1.

Test Plan:
- Reset and single word: rst high, then low; req0_valid = 1, data = 16'hA455 (42069), last = 1.
  - Cycle 1: grant 00 → 01.
  - Cycle 2: fifo_wr_en = 1, data A455, words0 = 1.
  - Cycle 3: grant = 00.
- Contention: both valid from IDLE with last = 0 continuously, BURST_MAX = 4.
  - G0 accepts 4 words, then switches directly to G1 with no idle cycle.
  - G1 accepts 4 words, then G0 again.
  - words0 = words1 = 4 after 9 cycles.
- Full stall: in G1 mid-burst with burst_cnt = 2, hold fifo_full = 1 for 5 cycles.
  - req1_ready = 0 and fifo_wr_en = 0 throughout; grant stays 10.
  - After full drops, exactly 2 more words (data 16'hFFFF, 16'h115C) are accepted before release.
- Early last: req0 sends 2 words with last on the 2nd while req1 is idle.
  - State goes IDLE after word 2; burst_cnt = 0.
  - A subsequent req0 request is re-granted after 1 arbitration cycle.
- Valid drop: req0 granted, drops valid after 1 word with no last.
  - Release next edge; grant passes to req1 if it is valid.
- Async reset mid-burst: assert rst between edges while in G0 with burst_cnt = 3.
  - grant, readies and fifo_wr_en go 0 immediately, counters clear, and no write occurs on the next edge.
- Counter wrap: with CNT_W = 4, accept 17 words from req1 → words1 = 1.
